data_ram_wr_sched: RTL and testbench
====================================

// Module: data_ram_wr_sched
//
// PURPOSE
//  Owns the single write port (port B) of the data RAM in the hash-table data table.
//  Shares that port between three sources:
//   - a built-in clear sweep, which zero-fills the RAM and seeds the empty-pointer list with every address;
//   - an insert writer;
//   - a delete/relink writer.
//  Sits between the insert/delete engines and the RAM.
//  Drives the RAM write port and the empty-pointer storage add port through registered outputs.
//
// PARAMETERS
//  A_WIDTH   10   RAM address width (= HEAD_PTR_WIDTH); RAM depth = 2**A_WIDTH
//  D_WIDTH   64   RAM word width (= $bits(ram_data_t))
//
// PORTS
//  clk_i               in   1        clock
//  rst_i               in   1        reset, asynchronous, active-high
//  clear_ram_run_i     in   1        1-cycle pulse: start (or restart) clear sweep
//  clear_ram_done_o    out  1        1-cycle pulse, coincident with the last clear write on ram_wr_*
//  busy_o              out  1        1 while in CLEAR
//  ins_wr_valid_i      in   1        insert write request
//  ins_wr_ready_o      out  1        insert request accepted this cycle
//  ins_wr_addr_i       in   A_WIDTH  insert write address
//  ins_wr_data_i       in   D_WIDTH  insert write data
//  del_wr_valid_i      in   1        delete write request
//  del_wr_ready_o      out  1        delete request accepted this cycle
//  del_wr_addr_i       in   A_WIDTH  delete write address
//  del_wr_data_i       in   D_WIDTH  delete write data
//  ram_wr_addr_o       out  A_WIDTH  RAM port B address (registered)
//  ram_wr_data_o       out  D_WIDTH  RAM port B data (registered)
//  ram_wr_en_o         out  1        RAM port B write enable (registered)
//  add_empty_ptr_o     out  A_WIDTH  address pushed to empty-pointer storage (registered)
//  add_empty_ptr_en_o  out  1        push strobe (registered)
//
// BEHAVIOUR
//  Reset values:
//   - all outputs 0; state IDLE; clear_addr 0; last_grant = DEL, so INS wins the first tie.
//  FSM (2 states):
//   - IDLE -> CLEAR on clear_ram_run_i.
//   - CLEAR -> IDLE in the cycle clear_addr == '1 is issued.
//   - clear_ram_run_i while in CLEAR restarts the sweep: clear_addr <= 0, no done pulse for the aborted sweep.
//  CLEAR operation:
//   - Each cycle issues one write: addr = clear_addr, data = '0, en = 1.
//   - Same cycle issues add_empty_ptr = clear_addr, en = 1.
//   - clear_addr += 1 per cycle.
//   - The sweep takes exactly 2**A_WIDTH cycles; address '1 is included.
//   - clear_addr wraps only on restart.
//  Handshake rules:
//   - Valid/ready. Requesters hold valid, addr and data stable until ready.
//   - ready is combinational from state, valid and last_grant.
//   - Both ready outputs are 0 in CLEAR and in any IDLE cycle where clear_ram_run_i = 1, because clear has priority.
//  Arbitration in IDLE:
//   - Only one requester valid: it gets ready.
//   - Both valid: the requester not equal to last_grant wins (round-robin).
//   - last_grant updates only on an accepted request.
//   - Writes to the same address are not merged; each is issued in acceptance order.
//  Latency:
//   - An accepted request or clear step appears on ram_wr_* exactly 1 cycle later.
//   - At most one write per cycle; throughput is 1 write/cycle.
//  Idle outputs:
//   - With no write issued, ram_wr_en_o = 0, ram_wr_addr_o = 0, ram_wr_data_o = 0.
//   - add_empty_ptr_en_o = 0 and add_empty_ptr_o = 0.
//  clear_ram_done_o:
//   - Registered; high in the same cycle as ram_wr_en_o for address '1.
//   - A request accepted in that cycle (state already IDLE) is written on the following cycle, so there is no gap.
//  Reset mid-sweep: everything returns to reset values immediately; no done pulse.
//  busy_o = (state == CLEAR).
//
// TESTING (A_WIDTH = 4 for sim)
//  1. Pulse clear_ram_run_i at t0.
//     -> 16 consecutive writes, addr 0..15, data 0, from t0+2.
//     -> 16 add_empty_ptr pushes 0..15, same cycles as the writes.
//     -> done pulse with addr 15; busy_o high for 16 cycles.
//  2. ins valid alone, addr 5, data 0xAA.
//     -> ready same cycle.
//     -> next cycle wr_en = 1, addr 5, data 0xAA.
//  3. ins and del both valid, held for 4 cycles after reset.
//     -> grants alternate INS, DEL, INS, DEL.
//     -> 4 back-to-back writes in that order.
//  4. del valid during CLEAR.
//     -> del_wr_ready_o stays 0 until the done-pulse cycle.
//     -> del is accepted in that cycle; its write appears on the cycle after addr 15.
//  5. clear_ram_run_i re-pulsed when clear_addr = 9.
//     -> the next write addr is 0 and the sweep runs a full 16 more cycles.
//     -> exactly one done pulse.
//  6. Assert rst_i at clear_addr = 7.
//     -> all outputs 0 asynchronously.
//     -> after release, ins requests are accepted and no stray done pulse occurs.

Source files
------------

// File: rtl/data_ram_wr_sched.sv
// rtl/data_ram_wr_sched.sv - data RAM port-B write scheduler: clear sweep, insert and delete writers
module data_ram_wr_sched #(
   parameter int A_WIDTH = 10,
   parameter int D_WIDTH = 64
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clear_ram_run_i,
   output logic               clear_ram_done_o,
   output logic               busy_o,
   input  logic               ins_wr_valid_i,
   output logic               ins_wr_ready_o,
   input  logic [A_WIDTH-1:0] ins_wr_addr_i,
   input  logic [D_WIDTH-1:0] ins_wr_data_i,
   input  logic               del_wr_valid_i,
   output logic               del_wr_ready_o,
   input  logic [A_WIDTH-1:0] del_wr_addr_i,
   input  logic [D_WIDTH-1:0] del_wr_data_i,
   output logic [A_WIDTH-1:0] ram_wr_addr_o,
   output logic [D_WIDTH-1:0] ram_wr_data_o,
   output logic               ram_wr_en_o,
   output logic [A_WIDTH-1:0] add_empty_ptr_o,
   output logic               add_empty_ptr_en_o
);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   typedef enum logic {
      GRANT_INS = 1'b0,
      GRANT_DEL = 1'b1
   } grant_t;

   localparam logic [A_WIDTH-1:0] ADDR_ONE = A_WIDTH'(1);

   state_t             state;
   grant_t             last_grant;
   logic [A_WIDTH-1:0] clear_addr;
   logic               accept_ok;

   // Requests are only taken in IDLE and never in a cycle that starts a sweep;
   // on a tie the requester that did not win last time is served.
   always_comb begin
      accept_ok      = (state == IDLE) && !clear_ram_run_i;
      ins_wr_ready_o = accept_ok && ins_wr_valid_i &&
                       (!del_wr_valid_i || (last_grant == GRANT_DEL));
      del_wr_ready_o = accept_ok && del_wr_valid_i &&
                       (!ins_wr_valid_i || (last_grant == GRANT_INS));
   end

   assign busy_o = (state == CLEAR);

   // Sweep FSM, arbitration history and the registered RAM / empty-pointer outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state              <= IDLE;
         last_grant         <= GRANT_DEL;
         clear_addr         <= '0;
         ram_wr_en_o        <= 1'b0;
         ram_wr_addr_o      <= '0;
         ram_wr_data_o      <= '0;
         add_empty_ptr_en_o <= 1'b0;
         add_empty_ptr_o    <= '0;
         clear_ram_done_o   <= 1'b0;
      end else begin
         // Idle-cycle values; overridden below when a write is issued.
         ram_wr_en_o        <= 1'b0;
         ram_wr_addr_o      <= '0;
         ram_wr_data_o      <= '0;
         add_empty_ptr_en_o <= 1'b0;
         add_empty_ptr_o    <= '0;
         clear_ram_done_o   <= 1'b0;

         case (state)
            IDLE: begin
               if (clear_ram_run_i) begin
                  state      <= CLEAR;
                  clear_addr <= '0;
               end else if (ins_wr_ready_o) begin
                  ram_wr_en_o   <= 1'b1;
                  ram_wr_addr_o <= ins_wr_addr_i;
                  ram_wr_data_o <= ins_wr_data_i;
                  last_grant    <= GRANT_INS;
               end else if (del_wr_ready_o) begin
                  ram_wr_en_o   <= 1'b1;
                  ram_wr_addr_o <= del_wr_addr_i;
                  ram_wr_data_o <= del_wr_data_i;
                  last_grant    <= GRANT_DEL;
               end
            end

            CLEAR: begin
               if (clear_ram_run_i) begin
                  // Restart: the aborted sweep gets no done pulse and the
                  // new sweep starts from address 0 on the next cycle.
                  clear_addr <= '0;
               end else begin
                  ram_wr_en_o        <= 1'b1;
                  ram_wr_addr_o      <= clear_addr;
                  add_empty_ptr_en_o <= 1'b1;
                  add_empty_ptr_o    <= clear_addr;
                  clear_addr         <= clear_addr + ADDR_ONE;
                  if (clear_addr == '1) begin
                     state            <= IDLE;
                     clear_ram_done_o <= 1'b1;
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_ram_wr_sched.sv
// tb/tb_data_ram_wr_sched.sv - self-checking bench for data_ram_wr_sched
module tb_data_ram_wr_sched;

   localparam int AW = 4;
   localparam int DW = 64;
   localparam int DEPTH = 1 << AW;

   logic          clk;
   logic          rst;
   logic          run;
   logic          done;
   logic          busy;
   logic          iv;
   logic          ir;
   logic [AW-1:0] ia;
   logic [DW-1:0] id;
   logic          dv;
   logic          dr;
   logic [AW-1:0] da;
   logic [DW-1:0] dd;
   logic [AW-1:0] wa;
   logic [DW-1:0] wd;
   logic          we;
   logic [AW-1:0] pa;
   logic          pe;

   data_ram_wr_sched #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .clear_ram_run_i    (run),
      .clear_ram_done_o   (done),
      .busy_o             (busy),
      .ins_wr_valid_i     (iv),
      .ins_wr_ready_o     (ir),
      .ins_wr_addr_i      (ia),
      .ins_wr_data_i      (id),
      .del_wr_valid_i     (dv),
      .del_wr_ready_o     (dr),
      .del_wr_addr_i      (da),
      .del_wr_data_i      (dd),
      .ram_wr_addr_o      (wa),
      .ram_wr_data_o      (wd),
      .ram_wr_en_o        (we),
      .add_empty_ptr_o    (pa),
      .add_empty_ptr_en_o (pe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: sweep progress as a count of remaining clear writes,
   // plus the expected registered outputs for the current cycle.
   int            m_left;
   int            m_next;
   bit            m_last_ins;
   logic          e_en, e_pe, e_done;
   logic [AW-1:0] e_addr, e_pa;
   logic [DW-1:0] e_data;

   // Values observed in the most recent cycle.
   logic          got_ir, got_dr, got_we, got_done, got_busy;
   logic [AW-1:0] got_wa;
   logic [DW-1:0] got_wd;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_left     = 0;
      m_next     = 0;
      m_last_ins = 1'b0;
      e_en = 1'b0; e_pe = 1'b0; e_done = 1'b0;
      e_addr = '0; e_pa = '0; e_data = '0;
   endtask

   // One clock cycle: inputs already driven; check at negedge, advance model.
   task automatic cycle();
      bit allow, m_ir, m_dr;
      @(negedge clk);
      allow = (m_left == 0) && !run;
      m_ir  = allow && iv && (!dv || !m_last_ins);
      m_dr  = allow && dv && (!iv || m_last_ins);
      got_ir = ir; got_dr = dr; got_we = we; got_wa = wa; got_wd = wd;
      got_done = done; got_busy = busy;
      check("ins_ready", 64'(ir), 64'(m_ir));
      check("del_ready", 64'(dr), 64'(m_dr));
      check("busy", 64'(busy), 64'(m_left != 0));
      check("wr_en", 64'(we), 64'(e_en));
      check("wr_addr", 64'(wa), 64'(e_addr));
      check("wr_data", wd, e_data);
      check("ptr_en", 64'(pe), 64'(e_pe));
      check("ptr_addr", 64'(pa), 64'(e_pa));
      check("done", 64'(done), 64'(e_done));
      e_en = 1'b0; e_pe = 1'b0; e_done = 1'b0;
      e_addr = '0; e_pa = '0; e_data = '0;
      if (run) begin
         m_left = DEPTH;
         m_next = 0;
      end else if (m_left != 0) begin
         e_en   = 1'b1;
         e_addr = AW'(m_next);
         e_pe   = 1'b1;
         e_pa   = AW'(m_next);
         e_done = (m_left == 1);
         m_left = m_left - 1;
         m_next = m_next + 1;
      end else if (m_ir) begin
         e_en = 1'b1; e_addr = ia; e_data = id; m_last_ins = 1'b1;
      end else if (m_dr) begin
         e_en = 1'b1; e_addr = da; e_data = dd; m_last_ins = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      run = 1'b0; iv = 1'b0; dv = 1'b0;
      ia = '0; id = '0; da = '0; dd = '0;
   endtask

   // Reset asserted mid-cycle; outputs must clear without waiting for an edge.
   task automatic apply_reset(input string tag);
      rst = 1'b1;
      #1;
      check({tag, "_rst_we"}, 64'(we), 64'd0);
      check({tag, "_rst_wa"}, 64'(wa), 64'd0);
      check({tag, "_rst_wd"}, wd, 64'd0);
      check({tag, "_rst_pe"}, 64'(pe), 64'd0);
      check({tag, "_rst_pa"}, 64'(pa), 64'd0);
      check({tag, "_rst_done"}, 64'(done), 64'd0);
      check({tag, "_rst_busy"}, 64'(busy), 64'd0);
      idle_inputs();
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   typedef struct {
      logic          iv;
      logic [AW-1:0] ia;
      logic [DW-1:0] id;
      logic          dv;
      logic [AW-1:0] da;
      logic [DW-1:0] dd;
      logic          ir;
      logic          dr;
      logic          en;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } vec_t;

   vec_t tbl[8];

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int busy_cnt, done_cnt, wr_cnt, push_cnt, first_wr, k, found, first_addr;

      // Both valid after reset: INS, DEL, INS, DEL; then lone INS (addr 5, AA); lone DEL.
      tbl[0] = '{1'b1, 4'd1, 64'h11, 1'b1, 4'd2, 64'h22, 1'b1, 1'b0, 1'b0, 4'd0, 64'h0};
      tbl[1] = '{1'b1, 4'd3, 64'h33, 1'b1, 4'd2, 64'h22, 1'b0, 1'b1, 1'b1, 4'd1, 64'h11};
      tbl[2] = '{1'b1, 4'd3, 64'h33, 1'b1, 4'd4, 64'h44, 1'b1, 1'b0, 1'b1, 4'd2, 64'h22};
      tbl[3] = '{1'b1, 4'd5, 64'hAA, 1'b1, 4'd4, 64'h44, 1'b0, 1'b1, 1'b1, 4'd3, 64'h33};
      tbl[4] = '{1'b1, 4'd5, 64'hAA, 1'b0, 4'd0, 64'h0,  1'b1, 1'b0, 1'b1, 4'd4, 64'h44};
      tbl[5] = '{1'b0, 4'd0, 64'h0,  1'b1, 4'd6, 64'h66, 1'b0, 1'b1, 1'b1, 4'd5, 64'hAA};
      tbl[6] = '{1'b0, 4'd0, 64'h0,  1'b0, 4'd0, 64'h0,  1'b0, 1'b0, 1'b1, 4'd6, 64'h66};
      tbl[7] = '{1'b0, 4'd0, 64'h0,  1'b0, 4'd0, 64'h0,  1'b0, 1'b0, 1'b0, 4'd0, 64'h0};

      rst = 1'b1;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      apply_reset("init");

      // Table-driven arbitration and latency vectors.
      for (int i = 0; i < 8; i++) begin
         iv = tbl[i].iv; ia = tbl[i].ia; id = tbl[i].id;
         dv = tbl[i].dv; da = tbl[i].da; dd = tbl[i].dd;
         cycle();
         check($sformatf("tbl%0d_ir", i), 64'(got_ir), 64'(tbl[i].ir));
         check($sformatf("tbl%0d_dr", i), 64'(got_dr), 64'(tbl[i].dr));
         check($sformatf("tbl%0d_en", i), 64'(got_we), 64'(tbl[i].en));
         check($sformatf("tbl%0d_addr", i), 64'(got_wa), 64'(tbl[i].addr));
         check($sformatf("tbl%0d_data", i), got_wd, tbl[i].data);
      end
      idle_inputs();

      // Full clear sweep.
      run = 1'b1;
      cycle();
      run = 1'b0;
      busy_cnt = 0; done_cnt = 0; wr_cnt = 0; push_cnt = 0; first_wr = -1;
      for (int c = 1; c <= 20; c++) begin
         cycle();
         if (got_busy) busy_cnt++;
         if (got_done) done_cnt++;
         if (got_we) begin
            if (first_wr < 0) first_wr = c;
            check("sweep_addr_seq", 64'(got_wa), 64'(wr_cnt));
            wr_cnt++;
         end
         if (pe) push_cnt++;
      end
      check("sweep_busy_cycles", 64'(busy_cnt), 64'(DEPTH));
      check("sweep_done_pulses", 64'(done_cnt), 64'd1);
      check("sweep_writes", 64'(wr_cnt), 64'(DEPTH));
      check("sweep_pushes", 64'(push_cnt), 64'(DEPTH));
      check("sweep_first_write", 64'(first_wr), 64'd2);

      // Delete request held during a sweep: accepted on the done-pulse cycle.
      run = 1'b1;
      cycle();
      run = 1'b0;
      dv = 1'b1; da = 4'd9; dd = 64'hD00D_BEEF;
      found = 0; k = 0;
      for (int c = 1; c <= 30 && found == 0; c++) begin
         cycle();
         if (got_dr) begin
            found = c;
            check("del_accept_with_done", 64'(got_done), 64'd1);
            check("del_accept_prev_addr", 64'(got_wa), 64'(DEPTH - 1));
         end
      end
      check("del_accept_cycle", 64'(found), 64'(DEPTH + 1));
      idle_inputs();
      cycle();
      check("del_write_en", 64'(got_we), 64'd1);
      check("del_write_addr", 64'(got_wa), 64'd9);
      check("del_write_data", got_wd, 64'hD00D_BEEF);

      // Restart while clear_addr is 9.
      run = 1'b1;
      cycle();
      run = 1'b0;
      found = 0;
      for (int c = 0; c < 20 && found == 0; c++) begin
         cycle();
         if (got_we && got_wa == 4'd7) found = 1;
      end
      check("restart_reached_addr7", 64'(found), 64'd1);
      run = 1'b1;
      cycle();
      run = 1'b0;
      wr_cnt = 0; done_cnt = 0; first_addr = -1;
      for (int c = 0; c < 22; c++) begin
         cycle();
         if (got_we) begin
            if (first_addr < 0) first_addr = int'(got_wa);
            wr_cnt++;
         end
         if (got_done) done_cnt++;
      end
      check("restart_first_addr", 64'(first_addr), 64'd0);
      check("restart_writes", 64'(wr_cnt), 64'(DEPTH));
      check("restart_done_pulses", 64'(done_cnt), 64'd1);

      // Reset while clear_addr is 7, then insert traffic and no stray done.
      run = 1'b1;
      cycle();
      run = 1'b0;
      found = 0;
      for (int c = 0; c < 20 && found == 0; c++) begin
         cycle();
         if (got_we && got_wa == 4'd5) found = 1;
      end
      check("reset_reached_addr5", 64'(found), 64'd1);
      apply_reset("mid");
      done_cnt = 0;
      iv = 1'b1; ia = 4'd3; id = 64'h1234;
      cycle();
      check("post_reset_ins_ready", 64'(got_ir), 64'd1);
      iv = 1'b0;
      for (int c = 0; c < 20; c++) begin
         cycle();
         if (got_done) done_cnt++;
      end
      check("post_reset_no_done", 64'(done_cnt), 64'd0);

      // Randomized traffic with occasional sweep starts; requesters hold until ready.
      got_ir = 1'b0; got_dr = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         if (!iv || got_ir) begin
            iv = ($urandom_range(0, 2) != 0);
            ia = AW'($urandom);
            id = {$urandom, $urandom};
         end
         if (!dv || got_dr) begin
            dv = ($urandom_range(0, 2) != 0);
            da = AW'($urandom);
            dd = {$urandom, $urandom};
         end
         run = ($urandom_range(0, 59) == 0);
         cycle();
      end
      idle_inputs();
      repeat (20) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
